// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath: sequences each instruction over shared memory/ALU,
// drives per-state datapath controls, counts retired instructions and traps illegal opcodes.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             memready,
    output logic             memreq,
    output logic             memwrite,
    output logic             iord,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             branch,
    output logic             pcen,
    output logic             regwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       pcsrc,
    output logic [1:0]       aluop,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECUTE,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t           r_state;
    logic [CNT_W-1:0] r_retired;
    logic             r_illegal;

    // Retirement is counted on the edge that leaves a final state back to FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_retired <= '0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH:    if (memready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECUTE;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default: begin
                            r_state   <= S_ILLEGAL;
                            r_illegal <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:   r_state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                S_MEMREAD:  if (memready) r_state <= S_MEMWB;
                S_MEMWRITE: begin
                    if (memready) begin
                        r_state   <= S_FETCH;
                        r_retired <= r_retired + CNT_W'(1);
                    end
                end
                S_EXECUTE:  r_state <= S_ALUWB;
                S_ADDIEX:   r_state <= S_ADDIWB;
                S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                    r_state   <= S_FETCH;
                    r_retired <= r_retired + CNT_W'(1);
                end
                S_ILLEGAL:  r_state <= S_ILLEGAL;
                default:    r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no state path can infer a latch.
        memreq   = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        regwrite = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        case (r_state)
            S_FETCH: begin
                memreq  = 1'b1;
                alusrcb = 2'b01;
                irwrite = memready;
                pcwrite = memready;
            end
            S_DECODE:   alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMREAD: begin
                memreq = 1'b1;
                iord   = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWRITE: begin
                memreq   = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:   regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: ;
        endcase
        // NOTE: reset kills every strobe in the same cycle so an in-flight access is abandoned.
        if (reset) begin
            memreq   = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            branch   = 1'b0;
            regwrite = 1'b0;
        end
        pcen = pcwrite | (branch & zero);
    end

    assign illegal = r_illegal;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues hand-derived control words per cycle,
// a negedge monitor pops and compares them; a CNT_W=4 copy shares the stimulus to check counter wrap.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic       memreq, memwrite, iord, irwrite, pcwrite, branch, pcen;
        logic       regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc, aluop;
        logic       illegal;
    } ctl_t;

    typedef struct {
        string       tag;
        ctl_t        ctl;
        int unsigned ret;
    } exp_t;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111;

    localparam ctl_t C_FETCH   = '{memreq:1'b1, irwrite:1'b1, pcwrite:1'b1, pcen:1'b1, alusrcb:2'b01, default:'0};
    localparam ctl_t C_FWAIT   = '{memreq:1'b1, alusrcb:2'b01, default:'0};
    localparam ctl_t C_DECODE  = '{alusrcb:2'b11, default:'0};
    localparam ctl_t C_MEMADR  = '{alusrca:1'b1, alusrcb:2'b10, default:'0};
    localparam ctl_t C_MEMREAD = '{memreq:1'b1, iord:1'b1, default:'0};
    localparam ctl_t C_MEMWB   = '{regwrite:1'b1, memtoreg:1'b1, default:'0};
    localparam ctl_t C_MEMWR   = '{memreq:1'b1, memwrite:1'b1, iord:1'b1, default:'0};
    localparam ctl_t C_EXEC    = '{alusrca:1'b1, aluop:2'b10, default:'0};
    localparam ctl_t C_ALUWB   = '{regwrite:1'b1, regdst:1'b1, default:'0};
    localparam ctl_t C_BR_T    = '{alusrca:1'b1, aluop:2'b01, pcsrc:2'b01, branch:1'b1, pcen:1'b1, default:'0};
    localparam ctl_t C_BR_N    = '{alusrca:1'b1, aluop:2'b01, pcsrc:2'b01, branch:1'b1, default:'0};
    localparam ctl_t C_ADDIEX  = '{alusrca:1'b1, alusrcb:2'b10, default:'0};
    localparam ctl_t C_ADDIWB  = '{regwrite:1'b1, default:'0};
    localparam ctl_t C_JUMP    = '{pcsrc:2'b10, pcwrite:1'b1, pcen:1'b1, default:'0};
    localparam ctl_t C_ILL     = '{illegal:1'b1, default:'0};
    localparam ctl_t C_RST_F   = '{alusrcb:2'b01, default:'0};
    localparam ctl_t C_RST_MW  = '{iord:1'b1, default:'0};

    logic        clk = 1'b0;
    logic        reset, zero, memready;
    logic [5:0]  op;
    logic        memreq, memwrite, iord, irwrite, pcwrite, branch, pcen;
    logic        regwrite, regdst, memtoreg, alusrca, illegal;
    logic [1:0]  alusrcb, pcsrc, aluop;
    logic [31:0] retired;
    logic        memreq_n, memwrite_n, iord_n, irwrite_n, pcwrite_n, branch_n, pcen_n;
    logic        regwrite_n, regdst_n, memtoreg_n, alusrca_n, illegal_n;
    logic [1:0]  alusrcb_n, pcsrc_n, aluop_n;
    logic [3:0]  retired_n;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t e;
    ctl_t act;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
        .memreq(memreq), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcwrite(pcwrite), .branch(branch), .pcen(pcen), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal), .retired(retired)
    );

    multicycle_ctrl #(.CNT_W(4)) dut_narrow (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
        .memreq(memreq_n), .memwrite(memwrite_n), .iord(iord_n), .irwrite(irwrite_n),
        .pcwrite(pcwrite_n), .branch(branch_n), .pcen(pcen_n), .regwrite(regwrite_n),
        .regdst(regdst_n), .memtoreg(memtoreg_n), .alusrca(alusrca_n), .alusrcb(alusrcb_n),
        .pcsrc(pcsrc_n), .aluop(aluop_n), .illegal(illegal_n), .retired(retired_n)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic mr, input logic z,
                        input logic [5:0] o, input ctl_t c, input int unsigned ret);
        reset    = rst;
        memready = mr;
        zero     = z;
        op       = o;
        q.push_back('{tag, c, ret});
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e   = q.pop_front();
            act = {memreq, memwrite, iord, irwrite, pcwrite, branch, pcen, regwrite, regdst,
                   memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal};
            check({e.tag, "/ctl"}, 32'(act), 32'(e.ctl));
            check({e.tag, "/retired"}, retired, e.ret);
            check({e.tag, "/retired4"}, {28'b0, retired_n}, e.ret % 16);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; memready = 1'b1; zero = 1'b0; op = RT;
        @(posedge clk);
        #1;
        step("rst",        1, 1, 0, RT,   C_RST_F,   0);
        // R-type: FETCH, DECODE, EXECUTE, ALUWB
        step("r_fetch",    0, 1, 0, RT,   C_FETCH,   0);
        step("r_decode",   0, 0, 0, RT,   C_DECODE,  0);
        step("r_exec",     0, 1, 0, RT,   C_EXEC,    0);
        step("r_aluwb",    0, 1, 0, RT,   C_ALUWB,   0);
        // LW with three wait cycles in MEMREAD
        step("lw_fetch",   0, 1, 0, LW,   C_FETCH,   1);
        step("lw_decode",  0, 1, 0, LW,   C_DECODE,  1);
        step("lw_memadr",  0, 1, 0, LW,   C_MEMADR,  1);
        step("lw_wait0",   0, 0, 0, LW,   C_MEMREAD, 1);
        step("lw_wait1",   0, 0, 0, LW,   C_MEMREAD, 1);
        step("lw_wait2",   0, 0, 0, LW,   C_MEMREAD, 1);
        step("lw_read",    0, 1, 0, LW,   C_MEMREAD, 1);
        step("lw_memwb",   0, 1, 0, LW,   C_MEMWB,   1);
        // BEQ taken then not taken
        step("beq_fetch",  0, 1, 1, BEQ,  C_FETCH,   2);
        step("beq_decode", 0, 1, 1, BEQ,  C_DECODE,  2);
        step("beq_taken",  0, 1, 1, BEQ,  C_BR_T,    2);
        step("bnt_fetch",  0, 1, 0, BEQ,  C_FETCH,   3);
        step("bnt_decode", 0, 1, 0, BEQ,  C_DECODE,  3);
        step("bnt_branch", 0, 1, 0, BEQ,  C_BR_N,    3);
        // ADDI, preceded by one FETCH wait
        step("ad_fwait",   0, 0, 0, ADDI, C_FWAIT,   4);
        step("ad_fetch",   0, 1, 0, ADDI, C_FETCH,   4);
        step("ad_decode",  0, 1, 0, ADDI, C_DECODE,  4);
        step("ad_ex",      0, 0, 0, ADDI, C_ADDIEX,  4);
        step("ad_wb",      0, 1, 0, ADDI, C_ADDIWB,  4);
        // SW completing immediately
        step("sw_fetch",   0, 1, 0, SW,   C_FETCH,   5);
        step("sw_decode",  0, 1, 0, SW,   C_DECODE,  5);
        step("sw_memadr",  0, 1, 0, SW,   C_MEMADR,  5);
        step("sw_write",   0, 1, 0, SW,   C_MEMWR,   5);
        // SW abandoned by reset while waiting; memready in the reset cycle must not retire it
        step("swr_fetch",  0, 1, 0, SW,   C_FETCH,   6);
        step("swr_decode", 0, 1, 0, SW,   C_DECODE,  6);
        step("swr_memadr", 0, 1, 0, SW,   C_MEMADR,  6);
        step("swr_wait",   0, 0, 0, SW,   C_MEMWR,   6);
        step("swr_reset",  1, 1, 0, SW,   C_RST_MW,  6);
        // 16 jumps: narrow counter wraps 15 -> 0
        for (int k = 0; k < 16; k++) begin
            step("j_fetch",  0, 1, 0, JMP, C_FETCH,  k);
            step("j_decode", 0, 1, 0, JMP, C_DECODE, k);
            step("j_jump",   0, 1, 0, JMP, C_JUMP,   k);
        end
        // Illegal opcode: absorbing, sticky, then cleared by reset
        step("il_fetch",   0, 1, 0, BAD,  C_FETCH,   16);
        step("il_decode",  0, 1, 0, BAD,  C_DECODE,  16);
        for (int k = 0; k < 20; k++) begin
            step("il_hold", 0, k[0], k[1], (k[2] ? JMP : BAD), C_ILL, 16);
        end
        step("il_reset",   1, 1, 0, RT,   C_ILL,     16);
        step("il_after",   0, 1, 0, RT,   C_FETCH,   0);
        @(negedge clk);
        #1;
        check("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
